// File: rtl/wb_select_stage.sv
// Writeback stage: picks the writeback source, extracts/extends load lanes,
// applies the set-condition override and registers the result with stall/flush.
module wb_select_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_INC = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        choose,
    input  logic [1:0]        sel,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic              set,
    input  logic              lower,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              we_in,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [31:0]       data_lo;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       lane32;
    logic              ext_bit;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] link_val;
    logic [DATA_W-1:0] sel_val;

    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign data_lo  = data[31:0];
    assign link_val = pc + DATA_W'(PC_INC);

    always_comb begin
        byte_lane = data_lo[{sel, 3'b000} +: 8];
        half_lane = sel[1] ? data_lo[31:16] : data_lo[15:0];
        case (size)
            2'b00:   lane32 = ld_unsigned ? {24'b0, byte_lane}
                                          : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   lane32 = ld_unsigned ? {16'b0, half_lane}
                                          : {{16{half_lane[15]}}, half_lane};
            default: lane32 = data_lo;
        endcase
        // Word loads carry their own sign bit into any bits above 31.
        ext_bit = ~ld_unsigned & lane32[31];
    end

    generate
        if (DATA_W > 32) begin : g_wide
            assign load_val = {{(DATA_W-32){ext_bit}}, lane32};
        end else begin : g_narrow
            assign load_val = lane32;
        end
    endgenerate

    always_comb begin
        case (choose)
            3'd1:    sel_val = load_val;
            3'd2:    sel_val = link_val;
            3'd3:    sel_val = lo;
            3'd4:    sel_val = hi;
            default: sel_val = result;
        endcase
        if (set) begin
            sel_val = {{(DATA_W-1){1'b0}}, lower};
        end
    end

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (flush) begin
            // Kill only the valid bit; payload stays put so forwarding muxes stay quiet.
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            we_d    = we_in;
            addr_d  = rd_in;
            data_d  = sel_val;
            if (in_valid) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_valid   = valid_q;
    assign wb_we      = valid_q & we_q & (addr_q != '0);
    assign wb_addr    = addr_q;
    assign wb_data    = data_q;
    assign fwd_valid  = wb_we;
    assign fwd_addr   = addr_q;
    assign fwd_data   = data_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage: expected register contents are queued
// when each cycle is driven and compared one edge later.
module tb_wb_select_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, stall, flush;
    logic [2:0]        choose;
    logic [1:0]        sel, size;
    logic              ld_unsigned, set, lower;
    logic [DATA_W-1:0] result, data, pc, lo, hi;
    logic [REG_AW-1:0] rd_in;
    logic              we_in;
    logic              wb_valid, wb_we, fwd_valid;
    logic [REG_AW-1:0] wb_addr, fwd_addr;
    logic [DATA_W-1:0] wb_data, fwd_data;
    logic [CNT_W-1:0]  retire_cnt;

    typedef struct {
        logic              v;
        logic              we;
        logic [REG_AW-1:0] a;
        logic [DATA_W-1:0] d;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    string      sb_tag[$];
    exp_t       exp_cur;
    logic [CNT_W-1:0] exp_cnt;
    int         n_checks = 0;
    int         n_fails  = 0;

    always #5 clk = ~clk;

    wb_select_stage #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_INC(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .choose(choose), .sel(sel), .size(size), .ld_unsigned(ld_unsigned),
        .set(set), .lower(lower), .result(result), .data(data), .pc(pc),
        .lo(lo), .hi(hi), .rd_in(rd_in), .we_in(we_in),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .retire_cnt(retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_in();
        in_valid = 0; choose = 0; sel = 0; size = 0; ld_unsigned = 0;
        set = 0; lower = 0; result = 0; data = 0; pc = 0; lo = 0; hi = 0;
        rd_in = 0; we_in = 0; stall = 0; flush = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'd0);
        chk({tag, ".wb_we"}, 64'(wb_we), 64'd0);
        chk({tag, ".wb_addr"}, 64'(wb_addr), 64'd0);
        chk({tag, ".wb_data"}, 64'(wb_data), 64'd0);
        chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'd0);
        chk({tag, ".fwd_addr"}, 64'(fwd_addr), 64'd0);
        chk({tag, ".fwd_data"}, 64'(fwd_data), 64'd0);
        chk({tag, ".retire_cnt"}, 64'(retire_cnt), 64'd0);
    endtask

    // Drive one cycle with the current inputs; nd is the value the bench
    // expects to be selected if this edge captures.
    task automatic cycle(input logic fl, input logic st, input logic [DATA_W-1:0] nd,
                         input string tag);
        exp_t  e;
        string t;
        logic  exp_we;
        flush = fl;
        stall = st;
        if (fl) begin
            exp_cur.v = 1'b0;
        end else if (!st) begin
            exp_cur.v  = in_valid;
            exp_cur.we = we_in;
            exp_cur.a  = rd_in;
            exp_cur.d  = nd;
            if (in_valid) exp_cnt = exp_cnt + 1'b1;
        end
        exp_cur.cnt = exp_cnt;
        sb.push_back(exp_cur);
        sb_tag.push_back(tag);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            exp_we = e.v & e.we & (e.a != 0);
            chk({t, ".wb_valid"}, 64'(wb_valid), 64'(e.v));
            chk({t, ".wb_we"}, 64'(wb_we), 64'(exp_we));
            chk({t, ".wb_addr"}, 64'(wb_addr), 64'(e.a));
            chk({t, ".wb_data"}, 64'(wb_data), 64'(e.d));
            chk({t, ".fwd_valid"}, 64'(fwd_valid), 64'(exp_we));
            chk({t, ".fwd_addr"}, 64'(fwd_addr), 64'(e.a));
            chk({t, ".fwd_data"}, 64'(fwd_data), 64'(e.d));
            chk({t, ".retire_cnt"}, 64'(retire_cnt), 64'(e.cnt));
            $display("cycle %-12s valid=%0b we=%0b addr=%0d data=%h cnt=%0d",
                     t, wb_valid, wb_we, wb_addr, wb_data, retire_cnt);
        end
        flush = 0;
        stall = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_in();
        rst_n   = 1'b0;
        exp_cur = '{v: 1'b0, we: 1'b0, a: '0, d: '0, cnt: '0};
        exp_cnt = '0;
        #3;
        check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Byte loads, signed then unsigned.
        in_valid = 1; we_in = 1; rd_in = 5; choose = 1; size = 2'b00; sel = 3;
        data = 32'h80FF7F01; ld_unsigned = 0;
        cycle(0, 0, 32'hFFFFFF80, "byte_s");
        ld_unsigned = 1;
        cycle(0, 0, 32'h00000080, "byte_u");
        ld_unsigned = 0; sel = 0;
        cycle(0, 0, 32'h00000001, "byte_s0");

        // Halfword (aligned and misaligned) and word loads.
        data = 32'h80017FFE; size = 2'b01; sel = 2;
        cycle(0, 0, 32'hFFFF8001, "half_hi");
        sel = 1;
        cycle(0, 0, 32'h00007FFE, "half_mis");
        ld_unsigned = 1; sel = 3;
        cycle(0, 0, 32'h00008001, "half_u");
        ld_unsigned = 0; size = 2'b10; sel = 3;
        cycle(0, 0, 32'h80017FFE, "word");

        // Other sources.
        result = 32'hCAFEF00D; pc = 32'hFFFFFFFC; lo = 32'h12345678; hi = 32'h9ABCDEF0;
        rd_in = 9; choose = 2;
        cycle(0, 0, 32'h00000000, "link_wrap");
        pc = 32'h00001000;
        cycle(0, 0, 32'h00001004, "link");
        choose = 3;
        cycle(0, 0, 32'h12345678, "lo");
        choose = 4;
        cycle(0, 0, 32'h9ABCDEF0, "hi");
        choose = 6;
        cycle(0, 0, 32'hCAFEF00D, "reserved6");
        choose = 0;
        cycle(0, 0, 32'hCAFEF00D, "result");

        // Set override beats choose.
        set = 1; lower = 1; choose = 1;
        cycle(0, 0, 32'h00000001, "set_1");
        lower = 0;
        cycle(0, 0, 32'h00000000, "set_0");
        set = 0;

        // Register 0 is never written.
        rd_in = 0; we_in = 1; choose = 0; result = 32'h11112222;
        cycle(0, 0, 32'h11112222, "r0");

        // Non-writing and non-valid captures.
        rd_in = 12; we_in = 0; result = 32'h33334444;
        cycle(0, 0, 32'h33334444, "no_we");
        in_valid = 0; we_in = 1; result = 32'h55556666;
        cycle(0, 0, 32'h55556666, "bubble");

        // Capture A, then stall three cycles while inputs change.
        in_valid = 1; rd_in = 7; result = 32'hA5A5A5A5;
        cycle(0, 0, 32'hA5A5A5A5, "cap_A");
        for (int i = 0; i < 3; i++) begin
            result = 32'h0BAD0000 + i; rd_in = 5'(20 + i);
            cycle(0, 1, 32'h0, "stall");
        end

        // Flush with stall and a valid incoming instruction.
        result = 32'hDEADBEEF;
        cycle(1, 1, 32'h0, "flush_stall");
        cycle(1, 0, 32'h0, "flush");

        // Mid-cycle asynchronous reset.
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        exp_cur = '{v: 1'b0, we: 1'b0, a: '0, d: '0, cnt: '0};
        exp_cnt = '0;
        #2 rst_n = 1'b1;

        // 17 valid captures wrap the 4-bit counter back to 1.
        choose = 0; we_in = 1;
        for (int i = 0; i < 17; i++) begin
            result = 32'h00010000 + i; rd_in = 5'(1 + (i % 31));
            cycle(0, 0, 32'h00010000 + i, "wrap");
        end
        chk("wrap_final.retire_cnt", 64'(retire_cnt), 64'd1);

        // Reset while stalled, between edges.
        stall = 1;
        #2 rst_n = 1'b0;
        #1 check_zero("rst_stall");
        #3 rst_n = 1'b1;
        stall = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
